// File: rtl/song_sequencer_if.sv
// Command, song-RAM write and display bus of the song sequencer.
// The master drives commands and RAM writes; the slave (sequencer) drives note/Led/status.
interface song_sequencer_if #(
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 4,
  parameter int DEPTH  = 32,
  parameter int LED_W  = 8
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ENT_W  = 1 + DUR_W + NOTE_W;

  logic              beat;
  logic              start;
  logic              stop;
  logic              pause;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ENT_W-1:0]  wr_data;
  logic [NOTE_W-1:0] note;
  logic [LED_W-1:0]  Led;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pos;

  modport master (
    output beat, start, stop, pause, wr_en, wr_addr, wr_data,
    input  note, Led, busy, done, pos
  );

  modport slave (
    input  beat, start, stop, pause, wr_en, wr_addr, wr_data,
    output note, Led, busy, done, pos
  );
endinterface

// File: rtl/song_sequencer.sv
// Auto-play sequencer: steps through a song RAM of {legato, dur, note} entries on beat strobes.
// Optional build macro SONG_LOOP_EN: at end of song wrap to entry 0 instead of stopping.
module song_sequencer #(
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 4,
  parameter int DEPTH  = 32,
  parameter int LED_W  = 8
) (
  input logic              CLK,
  input logic              RESET,
  song_sequencer_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int ENT_W  = 1 + DUR_W + NOTE_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP, PAUSE} state_t;

  logic [ENT_W-1:0] mem [DEPTH];

  state_t            state, state_n, ret, ret_n;
  logic [ADDR_W-1:0] pos, pos_n, pos_inc;
  logic [DUR_W-1:0]  rem, rem_n;
  logic [NOTE_W-1:0] cnote, cnote_n;
  logic              cleg, cleg_n;
  logic              done_n, adv;
  logic [ENT_W-1:0]  ent0, entn;
  logic [NOTE_W-1:0] note_q, note_n;
  logic [LED_W-1:0]  led_q, led_n, oh;
  logic              done_q;

  // Asynchronous read: a fetch on the same edge as a write sees the old entry.
  always_ff @(posedge CLK)
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;

  assign pos_inc = pos + 1'b1;
  assign ent0    = mem[0];
  assign entn    = mem[pos_inc];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      ret    <= IDLE;
      pos    <= '0;
      rem    <= '0;
      cnote  <= '0;
      cleg   <= 1'b0;
      note_q <= '0;
      led_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      ret    <= ret_n;
      pos    <= pos_n;
      rem    <= rem_n;
      cnote  <= cnote_n;
      cleg   <= cleg_n;
      note_q <= note_n;
      led_q  <= led_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    ret_n   = ret;
    pos_n   = pos;
    rem_n   = rem;
    cnote_n = cnote;
    cleg_n  = cleg;
    done_n  = 1'b0;
    adv     = 1'b0;
    if (bus.stop) begin
      state_n = IDLE;
      pos_n   = '0;
      rem_n   = '0;
    end else if (bus.start) begin
      pos_n   = '0;
      cnote_n = ent0[NOTE_W-1:0];
      rem_n   = ent0[NOTE_W +: DUR_W];
      cleg_n  = ent0[ENT_W-1];
      if (ent0[NOTE_W +: DUR_W] != '0) state_n = PLAY;
      else begin
        state_n = IDLE;
        done_n  = (state == IDLE);   // a restart from busy never reports done
      end
    end else begin
      case (state)
        PLAY:
          if (bus.pause) begin
            ret_n   = PLAY;
            state_n = PAUSE;
          end else if (bus.beat) begin
            rem_n = rem - 1'b1;
            if (rem == DUR_W'(1)) begin
              if (cleg) adv = 1'b1;
              else      state_n = GAP;
            end
          end
        GAP:
          if (bus.pause) begin
            ret_n   = GAP;
            state_n = PAUSE;
          end else if (bus.beat) adv = 1'b1;
        PAUSE:
          if (bus.pause) state_n = ret;
        default: ;
      endcase
      if (adv) begin
        if (pos == LAST || entn[NOTE_W +: DUR_W] == '0) begin
          done_n = 1'b1;
          pos_n  = '0;
`ifdef SONG_LOOP_EN
          cnote_n = ent0[NOTE_W-1:0];
          rem_n   = ent0[NOTE_W +: DUR_W];
          cleg_n  = ent0[ENT_W-1];
          state_n = (ent0[NOTE_W +: DUR_W] != '0) ? PLAY : IDLE;
`else
          rem_n   = '0;
          state_n = IDLE;
`endif
        end else begin
          pos_n   = pos_inc;
          cnote_n = entn[NOTE_W-1:0];
          rem_n   = entn[NOTE_W +: DUR_W];
          cleg_n  = entn[ENT_W-1];
          state_n = PLAY;
        end
      end
    end
  end

  // Outputs are registered from the next state so they settle one edge after the command.
  always_comb begin
    for (int i = 0; i < LED_W; i++) oh[i] = (int'(cnote_n) == i + 1);
    note_n = '0;
    led_n  = led_q;
    case (state_n)
      IDLE: led_n = '0;
      PLAY: begin
        note_n = cnote_n;
        led_n  = oh;
      end
      default: ;
    endcase
  end

  assign bus.note = note_q;
  assign bus.Led  = led_q;
  assign bus.done = done_q;
  assign bus.busy = (state != IDLE);
  assign bus.pos  = pos;
endmodule

// File: tb/tb_song_sequencer.sv
// Directed self-checking bench for song_sequencer; honours SONG_LOOP_EN like the RTL.
module tb_song_sequencer;
`ifdef SONG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  song_sequencer_if #(.NOTE_W(4), .DUR_W(4), .DEPTH(32), .LED_W(8)) sif ();
  song_sequencer #(.NOTE_W(4), .DUR_W(4), .DEPTH(32), .LED_W(8)) dut (
    .CLK(clk), .RESET(rst), .bus(sif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ent(input logic leg, input logic [3:0] dur, input logic [3:0] nt);
    return {leg, dur, nt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [8:0] d);
    sif.wr_en = 1'b1; sif.wr_addr = 5'(a); sif.wr_data = d;
    tick();
    sif.wr_en = 1'b0;
  endtask

  task automatic do_start();
    sif.start = 1'b1; tick(); sif.start = 1'b0;
  endtask

  task automatic do_stop();
    sif.stop = 1'b1; tick(); sif.stop = 1'b0;
  endtask

  task automatic do_pause();
    sif.pause = 1'b1; tick(); sif.pause = 1'b0;
  endtask

  task automatic beat1();
    sif.beat = 1'b1; tick(); sif.beat = 1'b0;
  endtask

  // Beat strobe spaced ten cycles apart.
  task automatic beat10();
    repeat (9) tick();
    beat1();
  endtask

  task automatic song_a();
    wr(0, ent(1'b0, 4'd2, 4'd3));
    wr(1, ent(1'b1, 4'd1, 4'd4));
    wr(2, ent(1'b0, 4'd0, 4'd0));
  endtask

  initial begin
    sif.beat = 0; sif.start = 0; sif.stop = 0; sif.pause = 0;
    sif.wr_en = 0; sif.wr_addr = '0; sif.wr_data = '0;
    #3;
    chk("rst_note", 32'(sif.note), 0);
    chk("rst_led",  32'(sif.Led), 0);
    chk("rst_busy", 32'(sif.busy), 0);
    chk("rst_done", 32'(sif.done), 0);
    chk("rst_pos",  32'(sif.pos), 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic song: E for 2 beats, gap, legato F for 1 beat, end.
    song_a();
    do_start();
    chk("a_note0", 32'(sif.note), 3);
    chk("a_busy0", 32'(sif.busy), 1);
    chk("a_led0",  32'(sif.Led), 32'h04);
    beat10();
    chk("a_note1", 32'(sif.note), 3);
    beat10();
    chk("a_gap",     32'(sif.note), 0);
    chk("a_gap_led", 32'(sif.Led), 32'h04);
    chk("a_gap_bsy", 32'(sif.busy), 1);
    beat10();
    chk("a_note2", 32'(sif.note), 4);
    chk("a_pos2",  32'(sif.pos), 1);
    chk("a_led2",  32'(sif.Led), 32'h08);
    chk("a_nodone", 32'(sif.done), 0);
    beat10();
    chk("a_done",  32'(sif.done), 1);
    chk("a_busyE", 32'(sif.busy), LOOP ? 1 : 0);
    chk("a_noteE", 32'(sif.note), LOOP ? 3 : 0);
    chk("a_ledE",  32'(sif.Led), LOOP ? 32'h04 : 0);
    tick();
    chk("a_done1", 32'(sif.done), 0);
    do_stop();

    // Empty song.
    wr(0, ent(1'b0, 4'd0, 4'd6));
    do_start();
    chk("e_done", 32'(sif.done), 1);
    chk("e_busy", 32'(sif.busy), 0);
    tick();
    chk("e_done1", 32'(sif.done), 0);
    chk("e_busy1", 32'(sif.busy), 0);

    // Pause mid-note: G for 4 beats, pause after one, five ignored beats.
    wr(0, ent(1'b0, 4'd4, 4'd5));
    wr(1, ent(1'b0, 4'd0, 4'd0));
    do_start();
    chk("p_note0", 32'(sif.note), 5);
    chk("p_led0",  32'(sif.Led), 32'h10);
    beat10();
    do_pause();
    chk("p_pnote", 32'(sif.note), 0);
    chk("p_pbusy", 32'(sif.busy), 1);
    for (int i = 0; i < 5; i++) begin
      beat10();
      chk("p_hold", 32'(sif.note), 0);
    end
    chk("p_pled", 32'(sif.Led), 32'h10);
    do_pause();
    chk("p_res", 32'(sif.note), 5);
    beat10();
    chk("p_b1", 32'(sif.note), 5);
    beat10();
    chk("p_b2", 32'(sif.note), 5);
    beat10();
    chk("p_b3", 32'(sif.note), 0);
    beat10();
    chk("p_done", 32'(sif.done), 1);
    do_stop();

    // Stop during GAP, then asynchronous reset during PLAY.
    song_a();
    do_start();
    beat1();
    beat1();
    chk("s_gap", 32'(sif.busy), 1);
    do_stop();
    chk("s_busy", 32'(sif.busy), 0);
    chk("s_done", 32'(sif.done), 0);
    chk("s_pos",  32'(sif.pos), 0);
    chk("s_led",  32'(sif.Led), 0);
    do_start();
    beat1();
    beat1();
    beat1();
    chk("r_note", 32'(sif.note), 4);
    #2 rst = 1'b1;
    #1;
    chk("r_anote", 32'(sif.note), 0);
    chk("r_aled",  32'(sif.Led), 0);
    chk("r_abusy", 32'(sif.busy), 0);
    chk("r_apos",  32'(sif.pos), 0);
    #1 rst = 1'b0;
    tick();
    do_start();
    chk("r_replay", 32'(sif.note), 3);
    beat1();
    beat1();
    beat1();
    chk("r_replay2", 32'(sif.note), 4);
    do_stop();

    // Full depth, all legato single beats.
    for (int i = 0; i < 32; i++) wr(i, ent(1'b1, 4'd1, 4'((i % 15) + 1)));
    do_start();
    for (int i = 0; i < 31; i++) begin
      chk("f_pos", 32'(sif.pos), 32'(i));
      beat1();
    end
    chk("f_pos31", 32'(sif.pos), 31);
    chk("f_note31", 32'(sif.note), 32'((31 % 15) + 1));
    chk("f_nodone", 32'(sif.done), 0);
    beat1();
    chk("f_done", 32'(sif.done), 1);
    chk("f_busy", 32'(sif.busy), LOOP ? 1 : 0);
    chk("f_wrap", 32'(sif.pos), 0);
    beat1();
    chk("f_done1", 32'(sif.done), 0);
    chk("f_pos1",  32'(sif.pos), LOOP ? 1 : 0);
    do_stop();

    // Simultaneous commands and write to the playing entry.
    wr(0, ent(1'b0, 4'd3, 4'd2));
    wr(1, ent(1'b0, 4'd0, 4'd0));
    sif.start = 1'b1; sif.stop = 1'b1;
    tick();
    sif.start = 1'b0; sif.stop = 1'b0;
    chk("c_ss_busy", 32'(sif.busy), 0);
    chk("c_ss_note", 32'(sif.note), 0);
    do_start();
    chk("c_note", 32'(sif.note), 2);
    sif.beat = 1'b1; sif.pause = 1'b1;
    tick();
    sif.beat = 1'b0; sif.pause = 1'b0;
    chk("c_bp_note", 32'(sif.note), 0);
    chk("c_bp_busy", 32'(sif.busy), 1);
    do_pause();
    chk("c_resume", 32'(sif.note), 2);
    wr(0, ent(1'b0, 4'd3, 4'd7));
    chk("c_wr_hold", 32'(sif.note), 2);
    beat1();
    beat1();
    chk("c_b2", 32'(sif.note), 2);
    beat1();
    chk("c_b3", 32'(sif.note), 0);
    beat1();
    chk("c_done", 32'(sif.done), 1);
    do_stop();
    do_start();
    chk("c_newnote", 32'(sif.note), 7);
    chk("c_newled",  32'(sif.Led), 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
# song_sequencer

Programmable, parametrised auto-play sequencer for the FPGA piano. A small song RAM holds entries of note code, duration in beats and a legato flag. On `start`, a playback FSM steps through the entries, timed by a beat strobe. It drives the same note-code bus consumed by the tone generator and an LED display, and adds pause/resume, stop and end-of-song detection.

## Interface
- `NOTE_W`, 4: note-code width; code 0 = none (silence).
- `DUR_W`, 4: duration field width, in beats; duration 0 = end-of-song marker.
- `DEPTH`, 32: song RAM entries; power of two, ≥2; `ADDR_W = $clog2(DEPTH)`.
- `LED_W`, 8: LED bar width.
- `CLK` in 1: system clock; the only clock.
- `RESET` in 1: asynchronous, active-high reset.
- `beat` in 1: one-CLK-cycle strobe per beat, synchronous to `CLK`; not used as a clock.
- `start` in 1: pulse; begin playback at entry 0.
- `stop` in 1: pulse; abort playback and return to idle.
- `pause` in 1: pulse; toggles pause while playing.
- `wr_en` in 1: song RAM write strobe.
- `wr_addr` in `ADDR_W`: write address.
- `wr_data` in `1+DUR_W+NOTE_W`: entry `{legato, dur, note}`.
- `note` out `NOTE_W`: current note code, registered.
- `Led` out `LED_W`: one-hot display of the last sounded note, registered.
- `busy` out 1: high in PLAY, GAP or PAUSE.
- `done` out 1: one-cycle pulse at natural end of song.
- `pos` out `ADDR_W`: index of the current entry.

## Operation
- The song RAM is not reset. Writes are accepted in any state and take effect the cycle after `wr_en`. An entry fetched on the same edge as its write uses the old data.
- States are IDLE, PLAY, GAP and PAUSE. Command priority per cycle: `stop` > `start` > `pause` > `beat`.
- IDLE: `note`=0, `Led`=0, `pos`=0. On `start`, entry 0 is fetched:
  - dur≠0: go to PLAY with remaining=dur.
  - dur=0: pulse `done` and stay in IDLE.
- PLAY: `note`=entry note. `Led`=bit (note−1) set for note 1..LED_W, otherwise 0. On each `beat`, remaining decrements. On the beat where remaining=1:
  - legato=1: advance immediately.
  - legato=0: go to GAP.
- GAP: `note`=0 and `Led` holds. On the next `beat`, advance.
- Advance: if `pos`=DEPTH−1, or entry `pos`+1 has dur=0, this is end of song. Otherwise `pos`+1, load the entry, go to PLAY.
- End of song: `done` pulses, then go to IDLE (see Configuration).
- PAUSE: entered from PLAY or GAP on `pause`.
  - `note`=0 and `Led` holds. `beat` is ignored; remaining, `pos` and the return state are frozen.
  - A second `pause` returns to the saved state. The note is re-sounded if that state was PLAY.
- `pause` in IDLE is ignored.
- `start` while busy restarts from entry 0 and does not pulse `done`.
- `stop` in any state: IDLE on the next cycle, `pos`=0, no `done`.

## Timing
- Reset values: `note`=0, `Led`=0, `busy`=0, `done`=0, `pos`=0, state IDLE, remaining=0.
- `start` at edge n: `note` and `busy` are valid after edge n+1 (one-cycle latency).
- A `beat` at edge n that ends a note: the next note or silence appears after edge n+1.
- Note on-time = dur beats. A non-legato entry adds exactly one silent beat.
- `done` is high for exactly one cycle, concurrent with the transition to IDLE.
- `beat` coincident with `pause` is ignored. `beat` coincident with `start` does not decrement the newly loaded entry.
- `RESET` asserted mid-song forces all outputs to their reset values asynchronously. The RAM contents are retained.

## Configuration
- `SONG_LOOP_EN` defined: at end of song, `pos` wraps to 0 and entry 0 is reloaded.
  - If entry 0 has dur≠0, go to PLAY; `done` still pulses once per pass and `busy` stays high.
  - If entry 0 has dur=0, go to IDLE.
- `SONG_LOOP_EN` undefined: end of song goes to IDLE with a `done` pulse.

## Test plan
- Reset state: write entries 0–2 = {0,2,E=3}, {1,1,F=4}, {0,0,0}; pulse `start`; strobe `beat` every 10 cycles. Expect `note`: 3 for 2 beats, 0 for 1 beat, 4 for 1 beat; then `done` pulses once, `busy`=0, `Led` back to 0. While note=3, `Led`=8'b00000100.
- Empty song: entry 0 dur=0, pulse `start`. Expect `done` the cycle after, `busy` never high.
- Pause mid-note: entry {0,4,G=5}. Pause after 1 beat, apply 5 beats, then resume. Expect `note`=0 during pause, then exactly 3 more beats of 5.
- Stop and reset mid-song: `stop` during GAP gives IDLE next cycle with no `done`. `RESET` during PLAY zeroes outputs immediately; a new `start` replays the RAM unchanged.
- Full depth: all DEPTH entries dur=1, legato=1. Expect `pos` to run 0..DEPTH−1.
  - Without `SONG_LOOP_EN`: `done` at wrap.
  - With `SONG_LOOP_EN`: `pos` wraps to 0, `done` pulses each pass, `busy` stays high.
- Simultaneous commands: `start`+`stop` in the same cycle gives IDLE. `beat`+`pause` gives PAUSE with no decrement. A write to the currently playing entry changes the note only on the next fetch.
